// File: rtl/bp_be_stride_detector.sv
// rtl/bp_be_stride_detector.sv - strided-load detector that opens and confirms loop discovery
package bp_be_stride_pkg;

   typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

   // Virtual address width carried by each processor configuration.
   function automatic int bp_vaddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 39;
         default:          return 39;
      endcase
   endfunction

endpackage

module bp_be_stride_detector
   import bp_be_stride_pkg::*;
 #(parameter bp_params_e bp_params_p      = e_bp_default_cfg
   , parameter int       entries_p        = 8
   , parameter int       conf_thresh_p    = 2
   , parameter int       confirm_thresh_p = 4
   , parameter int       timeout_p        = 256
   , localparam int      vaddr_width_p    = bp_vaddr_width(bp_params_p)
   )
  (input  logic                     clk_i
   , input  logic                     reset_i
   , input  logic                     ld_v_i
   , input  logic [vaddr_width_p-1:0] ld_pc_i
   , input  logic [vaddr_width_p-1:0] ld_eaddr_i
   , input  logic                     flush_i
   , input  logic                     loop_done_i
   , output logic                     start_discovery_o
   , output logic                     confirm_discovery_o
   , output logic [vaddr_width_p-1:0] striding_pc_o
   , output logic [15:0]              stride_o
   );

   localparam int idx_w_lp  = $clog2(entries_p);
   localparam int tag_w_lp  = vaddr_width_p - 2 - idx_w_lp;
   localparam int hcnt_w_lp = $clog2(confirm_thresh_p + 1);
   localparam int tcnt_w_lp = $clog2(timeout_p + 1);

   localparam logic [2:0]           conf_thresh_lp    = 3'(conf_thresh_p);
   localparam logic [hcnt_w_lp-1:0] confirm_thresh_lp = hcnt_w_lp'(confirm_thresh_p);
   localparam logic [tcnt_w_lp-1:0] timeout_lp        = tcnt_w_lp'(timeout_p);

   typedef enum logic [1:0] {e_idle, e_discover, e_locked} state_e;

   state_e state_r, state_n;

   // Direct-mapped training table.
   logic [entries_p-1:0]     valid_r;
   logic [tag_w_lp-1:0]      tag_r    [entries_p];
   logic [vaddr_width_p-1:0] addr_r   [entries_p];
   logic [15:0]              stride_r [entries_p];
   logic [1:0]               conf_r   [entries_p];

   logic [hcnt_w_lp-1:0] hcnt_r, hcnt_inc;
   logic [tcnt_w_lp-1:0] tcnt_r, tcnt_inc;

   logic [idx_w_lp-1:0]      idx;
   logic [tag_w_lp-1:0]      tag;
   logic [vaddr_width_p-1:0] d;
   logic [15:0]              d_lo;
   logic [1:0]               conf_upd;
   logic                     hit, fits, trained, conf_ge, load_ok, disc_match;
   logic                     start_n, confirm_n, disc_hit, disc_abort, disc_timeout;
   logic                     pc_lsb_unused;

   // Loads are word-aligned in the PC, so the two lowest bits carry no index or tag information.
   assign pc_lsb_unused = ^ld_pc_i[1:0];

   assign idx      = ld_pc_i[2 +: idx_w_lp];
   assign tag      = ld_pc_i[vaddr_width_p-1 -: tag_w_lp];
   assign hit      = valid_r[idx] & (tag_r[idx] == tag);
   assign d        = ld_eaddr_i - addr_r[idx];
   assign d_lo     = d[15:0];
   // Delta fits in 16 signed bits when everything from bit 15 up is pure sign extension.
   assign fits     = (&d[vaddr_width_p-1:15]) | ~(|d[vaddr_width_p-1:15]);
   assign trained  = hit & fits & (d_lo != 16'd0) & (d_lo == stride_r[idx]);
   assign conf_upd = ~trained ? 2'd0 : (conf_r[idx] == 2'd3) ? 2'd3 : conf_r[idx] + 2'd1;
   assign conf_ge  = ({1'b0, conf_upd} >= conf_thresh_lp);
   assign load_ok  = ld_v_i & ~flush_i;
   // A table miss during discovery means the stride history is gone, so it never counts as a match.
   assign disc_match = hit & (d == {{(vaddr_width_p-16){stride_o[15]}}, stride_o});
   assign hcnt_inc = hcnt_r + hcnt_w_lp'(1);
   assign tcnt_inc = tcnt_r + tcnt_w_lp'(1);

   // Event decode for the current load; confirmation takes priority over the timeout.
   always_comb begin
      start_n      = 1'b0;
      confirm_n    = 1'b0;
      disc_hit     = 1'b0;
      disc_abort   = 1'b0;
      disc_timeout = 1'b0;
      if (load_ok) begin
         case (state_r)
            e_idle: start_n = hit & conf_ge;
            e_discover: begin
               if (ld_pc_i == striding_pc_o) begin
                  disc_hit   = disc_match;
                  disc_abort = ~disc_match;
                  confirm_n  = disc_match & (hcnt_inc == confirm_thresh_lp);
               end
               disc_timeout = (tcnt_inc == timeout_lp);
            end
            default: ;
         endcase
      end
   end

   // Next-state selection; flush overrides everything.
   always_comb begin
      state_n = state_r;
      case (state_r)
         e_idle:     if (start_n) state_n = e_discover;
         e_discover: begin
            if (confirm_n)                       state_n = e_locked;
            else if (disc_abort | disc_timeout)  state_n = e_idle;
         end
         e_locked:   if (loop_done_i) state_n = e_idle;
         default:    state_n = e_idle;
      endcase
      if (flush_i) state_n = e_idle;
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= e_idle;
      else         state_r <= state_n;
   end

   // Registered pulses and the stride latched when discovery opens; flush leaves the latch alone.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         start_discovery_o   <= 1'b0;
         confirm_discovery_o <= 1'b0;
         striding_pc_o       <= '0;
         stride_o            <= '0;
      end else begin
         start_discovery_o   <= start_n;
         confirm_discovery_o <= confirm_n;
         if (start_n) begin
            striding_pc_o <= ld_pc_i;
            stride_o      <= stride_r[idx];
         end
      end
   end

   // Discovery hit and load counters, restarted each time discovery opens.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hcnt_r <= '0;
         tcnt_r <= '0;
      end else if (start_n) begin
         hcnt_r <= '0;
         tcnt_r <= '0;
      end else if (load_ok && (state_r == e_discover)) begin
         tcnt_r <= tcnt_inc;
         if (disc_hit) hcnt_r <= hcnt_inc;
      end
   end

   // Table training runs in every state; a flush invalidates all entries and drops the load.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_r <= '0;
         for (int i = 0; i < entries_p; i++) begin
            tag_r[i]    <= '0;
            addr_r[i]   <= '0;
            stride_r[i] <= '0;
            conf_r[i]   <= '0;
         end
      end else if (flush_i) begin
         valid_r <= '0;
      end else if (ld_v_i) begin
         addr_r[idx] <= ld_eaddr_i;
         conf_r[idx] <= conf_upd;
         if (!hit) begin
            valid_r[idx]  <= 1'b1;
            tag_r[idx]    <= tag;
            stride_r[idx] <= 16'd0;
         end else if (!trained) begin
            stride_r[idx] <= d_lo;
         end
      end
   end

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// tb/tb_bp_be_stride_detector.sv - scoreboard bench for the stride detector
`timescale 1ns/1ps
module tb_bp_be_stride_detector;
   import bp_be_stride_pkg::*;

   localparam int     VW   = bp_vaddr_width(e_bp_default_cfg);
   localparam int     TH   = 2;
   localparam int     CT   = 4;
   localparam int     TO   = 12;
   localparam longint MASK = (longint'(1) << VW) - 1;
   localparam int     S_IDLE = 0, S_DISC = 1, S_LOCK = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ld_v = 1'b0;
   logic [VW-1:0] ld_pc = '0;
   logic [VW-1:0] ld_ea = '0;
   logic          flush = 1'b0;
   logic          loop_done = 1'b0;
   logic          start_o, confirm_o;
   logic [VW-1:0] spc;
   logic [15:0]   stride;

   bp_be_stride_detector #(.timeout_p(TO)) dut
     (.clk_i(clk), .reset_i(rst), .ld_v_i(ld_v), .ld_pc_i(ld_pc), .ld_eaddr_i(ld_ea)
      , .flush_i(flush), .loop_done_i(loop_done), .start_discovery_o(start_o)
      , .confirm_discovery_o(confirm_o), .striding_pc_o(spc), .stride_o(stride));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: table of trained strides plus a discovery state, in plain integers.
   typedef struct { bit v; longint tag; longint last; longint stride; int conf; } ent_t;
   typedef struct { int kind; int cyc; longint pc; longint stride; } exp_t;

   ent_t   tbl [8];
   int     m_st;
   longint m_pc, m_stride;
   int     m_hits, m_loads;
   exp_t   q [$];
   exp_t   mon_e;

   function automatic longint sdiff(longint a, longint b);
      longint x;
      x = (a - b) & MASK;
      if (x >= (MASK + 1) / 2) x = x - (MASK + 1);
      return x;
   endfunction

   function automatic longint trunc16(longint x);
      longint s;
      s = x & 64'hffff;
      if (s >= 32768) s = s - 65536;
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         tbl[k].v = 0; tbl[k].tag = 0; tbl[k].last = 0; tbl[k].stride = 0; tbl[k].conf = 0;
      end
      m_st = S_IDLE; m_pc = 0; m_stride = 0; m_hits = 0; m_loads = 0;
   endtask

   task automatic push_exp(input int kind);
      exp_t e;
      e.kind = kind; e.cyc = cyc + 1; e.pc = m_pc; e.stride = m_stride;
      q.push_back(e);
   endtask

   task automatic model_step(input bit v, input longint pc, input longint ea, input bit fl, input bit ld);
      int     i, orig;
      longint d;
      bit     hit, fits;
      if (fl) begin
         for (int k = 0; k < 8; k++) tbl[k].v = 0;
         m_st = S_IDLE;
         return;
      end
      orig = m_st;
      if (v) begin
         i    = int'((pc >> 2) & 7);
         hit  = tbl[i].v && (tbl[i].tag == (pc >> 5));
         d    = hit ? sdiff(ea, tbl[i].last) : 0;
         fits = (d >= -32768) && (d <= 32767);
         if (!hit) begin
            tbl[i].v = 1; tbl[i].tag = pc >> 5; tbl[i].stride = 0; tbl[i].conf = 0;
         end else if (fits && d != 0 && d == tbl[i].stride) begin
            tbl[i].conf = (tbl[i].conf == 3) ? 3 : tbl[i].conf + 1;
         end else begin
            tbl[i].stride = trunc16(d); tbl[i].conf = 0;
         end
         tbl[i].last = ea;
         if (orig == S_IDLE) begin
            if (hit && tbl[i].conf >= TH) begin
               m_st = S_DISC; m_pc = pc; m_stride = tbl[i].stride; m_hits = 0; m_loads = 0;
               push_exp(1);
            end
         end else if (orig == S_DISC) begin
            m_loads++;
            if (pc == m_pc) begin
               if (hit && d == m_stride) begin
                  m_hits++;
                  if (m_hits == CT) begin
                     m_st = S_LOCK;
                     push_exp(2);
                  end
               end else begin
                  m_st = S_IDLE;
               end
            end
            if (m_st == S_DISC && m_loads == TO) m_st = S_IDLE;
         end
      end
      if (orig == S_LOCK && ld) m_st = S_IDLE;
   endtask

   task automatic drive(input bit v, input longint pc, input longint ea, input bit fl, input bit ld);
      @(posedge clk); #1;
      ld_v = v; ld_pc = VW'(pc); ld_ea = VW'(ea); flush = fl; loop_done = ld;
      model_step(v, pc & MASK, ea & MASK, fl, ld);
   endtask

   task automatic load(input longint pc, input longint ea);
      drive(1'b1, pc, ea, 1'b0, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_flush();
      drive(1'b0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic phase_end(input string name);
      idle(); idle();
      @(negedge clk); #1;
      check({name, "_drained"}, q.size(), 0);
      check({name, "_latched_pc"}, longint'(spc), m_pc);
      check({name, "_latched_stride"}, longint'($signed(stride)), m_stride);
   endtask

   task automatic do_reset();
      idle();
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      q.delete();
      #3;
      check("rst_start", start_o, 0);
      check("rst_confirm", confirm_o, 0);
      check("rst_pc", longint'(spc), 0);
      check("rst_stride", longint'(stride), 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: every pulse pops the oldest expectation; overdue expectations count as missed.
   always @(negedge clk) begin
      if (!rst) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL missed_pulse: kind %0d due at cycle %0d, still pending at cycle %0d", q[0].kind, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (start_o || confirm_o) begin
            check("pulse_exclusive", longint'(start_o && confirm_o), 0);
            if (q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_pulse: start %0d confirm %0d at cycle %0d, expected none", start_o, confirm_o, cyc);
            end else begin
               mon_e = q.pop_front();
               check("pulse_kind", start_o ? 1 : 2, mon_e.kind);
               check("pulse_cycle", cyc, mon_e.cyc);
               check("pulse_pc", longint'(spc), mon_e.pc);
               check("pulse_stride", longint'($signed(stride)), mon_e.stride);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   longint rp [5];
   longint rs [5];
   longint ra [5];
   longint rea;
   int     rj, rr;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("init_start", start_o, 0);
      check("init_confirm", confirm_o, 0);
      check("init_pc", longint'(spc), 0);
      check("init_stride", longint'(stride), 0);
      rst = 1'b0;

      // Train, open discovery, confirm; loop_done during discovery is ignored.
      for (int k = 0; k < 8; k++) drive(1'b1, 64'h100, 64'h1000 + 8 * k, 1'b0, k == 5);
      idle();
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      load(64'h100, 64'h1040);
      load(64'h100, 64'h1048);
      phase_end("confirm");

      // Mismatching delta aborts discovery; a fresh start needs retraining.
      do_flush();
      for (int k = 0; k < 4; k++) load(64'h100, 64'h1000 + 8 * k);
      load(64'h100, 64'h2000);
      for (int k = 1; k < 4; k++) load(64'h100, 64'h2000 + 8 * k);
      phase_end("abort");

      // Non-fitting, zero and boundary deltas.
      do_flush();
      for (int k = 0; k < 6; k++) load(64'h200, 64'h10000 * k);
      for (int k = 0; k < 6; k++) load(64'h204, 64'h5000);
      for (int k = 0; k < 6; k++) load(64'h208, 64'h100000 + 64'h8000 * k);
      for (int k = 0; k < 6; k++) load(64'h20c, 64'h100000 - 64'h8000 * k);
      phase_end("delta");

      // Aliasing PCs evict each other.
      do_flush();
      for (int k = 0; k < 10; k++) load((k % 2) ? 64'h120 : 64'h100, 64'h4000 + 64'h1000 * (k % 2) + 8 * k);
      phase_end("alias");

      // Flush coincident with the fourth striding load.
      do_flush();
      for (int k = 0; k < 3; k++) load(64'h100, 64'h1000 + 8 * k);
      drive(1'b1, 64'h100, 64'h1018, 1'b1, 1'b0);
      phase_end("flush");
      for (int k = 4; k < 8; k++) load(64'h100, 64'h1000 + 8 * k);
      phase_end("after_flush");

      // Reset mid-discovery and mid-locked.
      do_flush();
      for (int k = 0; k < 6; k++) load(64'h100, 64'h1000 + 8 * k);
      do_reset();
      for (int k = 6; k < 10; k++) load(64'h100, 64'h1000 + 8 * k);
      phase_end("reset_disc");
      for (int k = 10; k < 16; k++) load(64'h100, 64'h1000 + 8 * k);
      do_reset();
      for (int k = 16; k < 18; k++) load(64'h100, 64'h1000 + 8 * k);
      phase_end("reset_lock");

      // Discovery times out after TO loads; negative stride.
      do_flush();
      for (int k = 0; k < 4; k++) load(64'h300, 64'h8000 - 4 * k);
      for (int k = 0; k < TO; k++) load(64'h404 + 4 * (k % 3), 64'h9000 + 64'h40 * k);
      for (int k = 4; k < 6; k++) load(64'h300, 64'h8000 - 4 * k);
      phase_end("timeout");

      // Randomized mix of strided streams, noise, flushes and loop_done.
      do_flush();
      rp = '{64'h100, 64'h104, 64'h120, 64'h140, 64'h300};
      rs = '{8, -16, 4, 64, 32};
      for (int k = 0; k < 5; k++) ra[k] = 64'h10000 * (k + 1);
      for (int n = 0; n < 3000; n++) begin
         rj = $urandom_range(0, 4);
         rr = $urandom_range(0, 99);
         if (rr < 88)      rea = ra[rj] + rs[rj];
         else if (rr < 94) rea = ra[rj];
         else              rea = {$urandom, $urandom};
         ra[rj] = rea & MASK;
         drive($urandom_range(0, 99) < 80, rp[rj], ra[rj], $urandom_range(0, 199) == 0,
               $urandom_range(0, 19) == 0);
      end
      phase_end("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_be_stride_detector.md
BP_BE_STRIDE_DETECTOR -- requirements
Module: bp_be_stride_detector

Interface
REQ-001 The block SHALL take parameter bp_params_p, default e_bp_default_cfg, which supplies vaddr_width_p through the processor parameter set.
REQ-002 The block SHALL take parameter entries_p, default 8 (power of two), giving the number of direct-mapped table entries.
REQ-003 The block SHALL take parameter conf_thresh_p, default 2, giving the confidence needed before a discovery start is issued.
REQ-004 The block SHALL take parameter confirm_thresh_p, default 4, giving the matching hits needed in DISCOVER before a confirm is issued.
REQ-005 The block SHALL take parameter timeout_p, default 256, giving the maximum number of loads allowed in DISCOVER.
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  reset, asynchronous and active-high.
REQ-008 ld_v_i  input  1  a committed load is presented this cycle.
REQ-009 ld_pc_i  input  vaddr_width_p  PC of the load.
REQ-010 ld_eaddr_i  input  vaddr_width_p  effective address of the load.
REQ-011 flush_i  input  1  pipeline flush.
REQ-012 loop_done_i  input  1  loop-inference result consumed, i.e. its valid and yumi both high.
REQ-013 start_discovery_o  output  1  one-cycle pulse that opens discovery.
REQ-014 confirm_discovery_o  output  1  one-cycle pulse that confirms the stride.
REQ-015 striding_pc_o  output  vaddr_width_p  latched PC of the striding load.
REQ-016 stride_o  output  16  latched signed stride in bytes.

Function
REQ-017 Table entries SHALL each hold valid, tag (ld_pc_i above index), last_addr (vaddr_width_p), stride (16-bit signed) and conf (2-bit saturating); the index is ld_pc_i[2 +: log2(entries_p)].
REQ-018 A load that misses (invalid entry or tag mismatch) SHALL allocate the entry: valid=1, tag written, last_addr=ld_eaddr_i, stride=0, conf=0.
REQ-019 A load that hits SHALL compute d = ld_eaddr_i - last_addr at full width; d is "fitting" if it is representable in signed 16 bits.
REQ-020 On a hit where d is fitting, nonzero, and equal to the stored stride, conf SHALL increment, saturating at 3; otherwise stride SHALL become d[15:0] and conf SHALL become 0.
REQ-021 last_addr SHALL be written with ld_eaddr_i on every hit; entry updates SHALL take effect at the edge that ends the load's cycle.
REQ-022 The FSM SHALL have three states: IDLE, DISCOVER, LOCKED; reset state is IDLE.
REQ-023 In IDLE, a hit whose updated conf is >= conf_thresh_p SHALL assert start_discovery_o for exactly the next cycle, latch striding_pc_o=ld_pc_i and stride_o=stride, clear the hit and timeout counters, and move to DISCOVER.
REQ-024 In DISCOVER, a load with ld_pc_i==striding_pc_o and d==stride_o SHALL increment the hit counter.
REQ-025 In DISCOVER, when the hit counter reaches confirm_thresh_p, confirm_discovery_o SHALL pulse for the next cycle and the FSM SHALL move to LOCKED.
REQ-026 In DISCOVER, a load at striding_pc_o with a different d, or timeout_p loads without confirmation, SHALL return the FSM to IDLE with no output pulse.
REQ-027 Table training SHALL continue in all states; new start pulses SHALL be suppressed outside IDLE.
REQ-028 In LOCKED, loop_done_i SHALL return the FSM to IDLE on the next edge; loop_done_i SHALL be ignored in other states.
REQ-029 flush_i SHALL clear every valid bit and force IDLE on the next edge; a load in the same cycle SHALL be dropped; striding_pc_o and stride_o SHALL hold their values.
REQ-030 All outputs SHALL be registered; start_discovery_o and confirm_discovery_o SHALL never both be high in one cycle.

Reset
REQ-031 While reset_i is high, asynchronously: FSM=IDLE, all valid bits=0, counters=0, start_discovery_o=0, confirm_discovery_o=0, striding_pc_o=0, stride_o=0.
REQ-032 Reset asserted mid-DISCOVER or mid-LOCKED SHALL abandon the operation; no pulse SHALL appear after deassertion until fresh training occurs.

Verification
REQ-033 Loads at pc 0x100 with addresses 0x1000, 0x1008, 0x1010, 0x1018 -> start_discovery_o pulses the cycle after the fourth load; striding_pc_o=0x100; stride_o=8.
REQ-034 Continuing the same sequence with 4 more loads (0x1020..0x1038) -> confirm_discovery_o pulses after the 8th load; FSM=LOCKED; a later loop_done_i -> IDLE.
REQ-035 In DISCOVER, a load at 0x100 with address 0x2000 -> FSM=IDLE, no confirm pulse; retraining is required before the next start.
REQ-036 Address delta 0x10000 (not fitting) or delta 0 -> conf stays 0; no start is issued.
REQ-037 Loads at pc 0x100 and 0x120 (same index for entries_p=8) alternating -> each evicts the other; no start is issued.
REQ-038 flush_i coincident with the 4th striding load -> no start pulse; the next load at 0x100 allocates fresh.
